// File: rtl/alu_ex_stage_pkg.sv
// Shared ALU definitions: opcodes, branch encodings, and the rules that decide
// which ALU flags are meaningful for a given opcode.
package alu_ex_stage_pkg;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3,
    ALU_SLL = 5'd4,
    ALU_SRA = 5'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BNE  = 2'd1,
    BR_BLT  = 2'd2,
    BR_RSVD = 2'd3
  } br_type_e;

  typedef struct packed {
    logic ne;
    logic lt;
    logic ovf;
  } alu_flags_t;

  // Overflow only means something for add/sub; compare flags only for sub.
  function automatic alu_flags_t mask_flags(input logic [4:0] op, input alu_flags_t raw);
    alu_flags_t f;
    f.ovf = raw.ovf & ((op == ALU_ADD) | (op == ALU_SUB));
    f.ne  = raw.ne & (op == ALU_SUB);
    f.lt  = raw.lt & (op == ALU_SUB);
    return f;
  endfunction

  function automatic logic branch_taken(input logic [1:0] br, input alu_flags_t f);
    return ((br == BR_BNE) & f.ne) | ((br == BR_BLT) & f.lt);
  endfunction

endpackage

// File: rtl/alu_ex_stage_alu.sv
// 32-bit combinational ALU: add/sub/and/or/sll/sra with raw ne, signed lt and
// overflow flags; unknown opcodes produce zero.
module alu
  import alu_ex_stage_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  aluop,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        ne,
  output logic        lt,
  output logic        ovf
);

  logic [31:0] sum;
  logic [31:0] diff;

  always_comb begin
    sum    = op_a + op_b;
    diff   = op_a - op_b;
    result = '0;
    ovf    = 1'b0;
    case (aluop)
      ALU_ADD: begin
        result = sum;
        ovf    = (op_a[31] == op_b[31]) & (sum[31] != op_a[31]);
      end
      ALU_SUB: begin
        result = diff;
        ovf    = (op_a[31] != op_b[31]) & (diff[31] != op_a[31]);
      end
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_SLL: result = op_a << shamt;
      ALU_SRA: result = 32'($signed(op_a) >>> shamt);
      default: result = '0;
    endcase
    ne = (op_a != op_b);
    lt = ($signed(op_a) < $signed(op_b));
  end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: one ALU evaluation per accepted op, flag masking and branch
// resolution, a 2-entry skid buffer toward memory/writeback, overflow counter.
module alu_ex_stage
  import alu_ex_stage_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_opA,
  input  logic [31:0]      in_opB,
  input  logic [4:0]       in_aluop,
  input  logic [4:0]       in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [1:0]       in_br,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ne,
  output logic             out_lt,
  output logic             out_ovf,
  output logic             out_taken,
  output logic [CNT_W-1:0] ovf_count
);

  logic [31:0] alu_result;
  logic        raw_ne, raw_lt, raw_ovf;
  alu_flags_t  new_flags;
  logic        new_taken;

  alu u_alu (
    .op_a   (in_opA),
    .op_b   (in_opB),
    .aluop  (in_aluop),
    .shamt  (in_shamt),
    .result (alu_result),
    .ne     (raw_ne),
    .lt     (raw_lt),
    .ovf    (raw_ovf)
  );

  always_comb begin
    new_flags = mask_flags(in_aluop, '{ne: raw_ne, lt: raw_lt, ovf: raw_ovf});
    new_taken = branch_taken(in_br, new_flags);
  end

  logic             m_valid, s_valid;
  logic [31:0]      m_result, s_result;
  logic [TAG_W-1:0] m_tag, s_tag;
  alu_flags_t       m_flags, s_flags;
  logic             m_taken, s_taken;

  logic consume, accept, m_load_new, m_load_s, s_load;
  logic m_valid_next, s_valid_next;

  // An incoming op only lands in S when M is occupied and stays occupied.
  always_comb begin
    consume      = m_valid & out_ready;
    accept       = in_valid & ~s_valid;
    m_load_new   = accept & (~m_valid | (consume & ~s_valid));
    m_load_s     = consume & s_valid;
    s_load       = accept & ~m_load_new;
    m_valid_next = m_load_new | m_load_s | (m_valid & ~consume);
    s_valid_next = s_load | (s_valid & ~consume);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      m_valid   <= 1'b0;
      s_valid   <= 1'b0;
      m_result  <= '0;
      m_tag     <= '0;
      m_flags   <= '0;
      m_taken   <= 1'b0;
      s_result  <= '0;
      s_tag     <= '0;
      s_flags   <= '0;
      s_taken   <= 1'b0;
      ovf_count <= '0;
    end else begin
      if (flush) begin
        m_valid <= 1'b0;
        s_valid <= 1'b0;
      end else begin
        m_valid <= m_valid_next;
        s_valid <= s_valid_next;
      end
      if (m_load_new) begin
        m_result <= alu_result;
        m_tag    <= in_tag;
        m_flags  <= new_flags;
        m_taken  <= new_taken;
      end else if (m_load_s) begin
        m_result <= s_result;
        m_tag    <= s_tag;
        m_flags  <= s_flags;
        m_taken  <= s_taken;
      end
      if (s_load) begin
        s_result <= alu_result;
        s_tag    <= in_tag;
        s_flags  <= new_flags;
        s_taken  <= new_taken;
      end
      if (consume && m_flags.ovf && (ovf_count != '1))
        ovf_count <= ovf_count + CNT_W'(1);
    end
  end

  assign in_ready   = ~s_valid;
  assign out_valid  = m_valid;
  assign out_result = m_result;
  assign out_tag    = m_tag;
  assign out_ne     = m_flags.ne;
  assign out_lt     = m_flags.lt;
  assign out_ovf    = m_flags.ovf;
  assign out_taken  = m_taken;

endmodule
